vpu_arbiter: RTL and testbench



---
 rtl/vpu_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vpu_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_arbiter.sv
// Round-robin front end sharing one vector_processor between NUM_REQ requesters,
// with a watchdog that aborts any operation whose vp_done never arrives.
module vpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [64*NUM_REQ-1:0]   req_vec_a,
  input  logic [64*NUM_REQ-1:0]   req_vec_b,
  input  logic [16*NUM_REQ-1:0]   req_scalar,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_result,
  output logic                    resp_err,
  output logic                    arb_busy,
  output logic                    vp_start,
  output logic [3:0]              vp_operation,
  output logic [63:0]             vp_vec_a,
  output logic [63:0]             vp_vec_b,
  output logic [15:0]             vp_scalar,
  input  logic                    vp_busy,
  input  logic                    vp_done,
  input  logic                    vp_result_valid,
  input  logic [63:0]             vp_result
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       result_q, result_d;
  logic              vp_start_q, vp_start_d;
  logic [3:0]        vp_op_q, vp_op_d;
  logic [63:0]       vp_a_q, vp_a_d, vp_b_q, vp_b_d;
  logic [15:0]       vp_scalar_q, vp_scalar_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [63:0]       resp_result_q, resp_result_d;

  logic              found, grant;
  logic [ID_W-1:0]   win_id, cand;
  logic [3:0]        win_op;
  logic [63:0]       win_a, win_b;
  logic [15:0]       win_scalar;

  // First valid port at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    win_id = rr_ptr_q;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    win_op     = '0;
    win_a      = '0;
    win_b      = '0;
    win_scalar = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_op     = req_op[4*i +: 4];
        win_a      = req_vec_a[64*i +: 64];
        win_b      = req_vec_b[64*i +: 64];
        win_scalar = req_scalar[16*i +: 16];
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && enable && !vp_busy && found;
  assign req_ready = (grant && !rst) ? (NUM_REQ'(1) << win_id) : '0;
  assign arb_busy  = (state_q != S_IDLE) && !rst;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    vp_start_d    = 1'b0;
    vp_op_d       = vp_op_q;
    vp_a_d        = vp_a_q;
    vp_b_d        = vp_b_q;
    vp_scalar_d   = vp_scalar_q;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          vp_op_d     = win_op;
          vp_a_d      = win_a;
          vp_b_d      = win_b;
          vp_scalar_d = win_scalar;
          id_d        = win_id;
          rr_ptr_d    = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
          vp_start_d  = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d    = '0;
        result_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (vp_result_valid) result_d = vp_result;
        // A result arriving together with done is the one returned.
        if (vp_done) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_id_d     = id_q;
          resp_err_d    = 1'b0;
          resp_result_d = vp_result_valid ? vp_result : result_q;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_id_d     = id_q;
          resp_err_d    = 1'b1;
          resp_result_d = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      vp_start_q    <= 1'b0;
      vp_op_q       <= '0;
      vp_a_q        <= '0;
      vp_b_q        <= '0;
      vp_scalar_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      vp_start_q    <= vp_start_d;
      vp_op_q       <= vp_op_d;
      vp_a_q        <= vp_a_d;
      vp_b_q        <= vp_b_d;
      vp_scalar_q   <= vp_scalar_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign vp_start     = vp_start_q;
  assign vp_operation = vp_op_q;
  assign vp_vec_a     = vp_a_q;
  assign vp_vec_b     = vp_b_q;
  assign vp_scalar    = vp_scalar_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_result  = resp_result_q;
  assign resp_err     = resp_err_q;
endmodule

// File: tb/tb_vpu_arbiter.sv
// Randomized bench for vpu_arbiter: a timeline model predicts grants and queues
// expected responses, which an independent monitor pops when resp_valid fires.
module tb_vpu_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [4*N-1:0]  req_op = '0;
  logic [64*N-1:0] req_vec_a = '0, req_vec_b = '0;
  logic [16*N-1:0] req_scalar = '0;
  logic            resp_valid, resp_err, arb_busy, vp_start;
  logic [1:0]      resp_id;
  logic [63:0]     resp_result, vp_vec_a, vp_vec_b;
  logic [3:0]      vp_operation;
  logic [15:0]     vp_scalar;
  logic            vp_busy = 1'b0, vp_done = 1'b0, vp_result_valid = 1'b0;
  logic [63:0]     vp_result = '0;

  vpu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b), .req_scalar(req_scalar),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_err(resp_err), .arb_busy(arb_busy), .vp_start(vp_start),
    .vp_operation(vp_operation), .vp_vec_a(vp_vec_a), .vp_vec_b(vp_vec_b),
    .vp_scalar(vp_scalar), .vp_busy(vp_busy), .vp_done(vp_done),
    .vp_result_valid(vp_result_valid), .vp_result(vp_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [63:0] result;
    logic        err;
    int          t_resp;
  } exp_t;

  exp_t exp_q[$];
  int   grants[$];
  int   n_checks = 0, n_pass = 0;

  // Requester state and stimulus knobs
  logic [N-1:0] pending = '0;
  logic [3:0]   p_op [N];
  logic [63:0]  p_a [N], p_b [N];
  logic [15:0]  p_s [N];
  logic [N-1:0] mask;
  int p_new, p_withdraw, p_busy, p_disable, lat_knob, rst_left;
  bit use_fixed = 0;

  // Timeline model of the operation in flight
  int          rr = 0;
  bit          active = 0, timeout_txn = 0;
  int          t_grant = -10, t_done = 0, t_last_wait = 0, t_resp = 0, t_final = -1;
  logic [63:0] final_val;
  logic [3:0]  g_op;
  logic [63:0] g_a, g_b;
  logic [15:0] g_s;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  // Monitor: every response must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL resp_unexpected at cycle %0d: got id %0d, expected no response", cyc, resp_id);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_id", 64'(resp_id), 64'(e.id));
          checkOutput("resp_result", resp_result, e.result);
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
          checkOutput("resp_cycle", 64'(cyc), 64'(e.t_resp));
        end
      end
    end
  end

  task automatic applyStimulus(input int n);
    int c, win, lat;
    logic [N-1:0] exp_ready;
    logic was_rst;
    exp_t e;
    for (int it = 0; it < n; it++) begin
      @(negedge clk);
      c = cyc;
      if (active && c > t_resp) active = 0;
      was_rst = rst;
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (rst) begin
        active = 0;
        rr = 0;
        exp_q.delete();
      end
      // VPU behaviour: only pulses inside the wait window may matter
      vp_done = 1'b0;
      vp_result_valid = 1'b0;
      vp_result = {$urandom, $urandom};
      if (active) begin
        if (c == t_grant + 1) begin
          if ($urandom_range(1) == 1) begin vp_done = 1'b1; vp_result_valid = 1'b1; end
        end else if (c <= t_last_wait) begin
          if (!timeout_txn && c == t_done) vp_done = 1'b1;
          if (c == t_final) begin
            vp_result_valid = 1'b1;
            vp_result = final_val;
          end else if ((timeout_txn || c < t_final) && $urandom_range(2) == 0) vp_result_valid = 1'b1;
        end else if ($urandom_range(1) == 1) begin
          vp_done = 1'b1; vp_result_valid = 1'b1;
        end
      end else if ($urandom_range(7) == 0) begin
        vp_done = 1'b1; vp_result_valid = 1'b1;
      end
      for (int p = 0; p < N; p++) begin
        if (pending[p]) begin
          if ($urandom_range(99) < p_withdraw) pending[p] = 1'b0;
        end else if (mask[p] && $urandom_range(99) < p_new) begin
          pending[p] = 1'b1;
          p_op[p] = 4'($urandom);
          p_a[p]  = {$urandom, $urandom};
          p_b[p]  = {$urandom, $urandom};
          p_s[p]  = 16'($urandom);
          if (use_fixed) begin p_op[p] = 4'h3; p_a[p] = 64'h0001_0002_0003_0004; end
          req_op[4*p +: 4]      = p_op[p];
          req_vec_a[64*p +: 64] = p_a[p];
          req_vec_b[64*p +: 64] = p_b[p];
          req_scalar[16*p +: 16] = p_s[p];
        end
        req_valid[p] = pending[p];
      end
      vp_busy = ($urandom_range(99) < p_busy);
      enable  = ($urandom_range(99) >= p_disable);
      #1;
      win = -1;
      if (!rst && !active && enable && !vp_busy)
        for (int k = 0; k < N; k++)
          if (win < 0 && pending[(rr + k) % N]) win = (rr + k) % N;
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
      checkOutput("arb_busy", 64'(arb_busy), 64'(!rst && active));
      checkOutput("vp_start", 64'(vp_start), 64'(active && c == t_grant + 1));
      if (active && c == t_grant + 1) begin
        checkOutput("vp_operation", 64'(vp_operation), 64'(g_op));
        checkOutput("vp_vec_a", vp_vec_a, g_a);
        checkOutput("vp_vec_b", vp_vec_b, g_b);
        checkOutput("vp_scalar", 64'(vp_scalar), 64'(g_s));
      end
      if (was_rst && !rst) begin
        checkOutput("rst_vp_operation", 64'(vp_operation), 64'd0);
        checkOutput("rst_vp_vec_a", vp_vec_a, 64'd0);
        checkOutput("rst_vp_vec_b", vp_vec_b, 64'd0);
        checkOutput("rst_vp_scalar", 64'(vp_scalar), 64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_id", 64'(resp_id), 64'd0);
        checkOutput("rst_resp_result", resp_result, 64'd0);
        checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
      end
      if (win >= 0) begin
        pending[win] = 1'b0;
        rr = (win + 1) % N;
        active = 1;
        t_grant = c;
        g_op = p_op[win]; g_a = p_a[win]; g_b = p_b[win]; g_s = p_s[win];
        timeout_txn = (lat_knob == -2) || (lat_knob == -1 && $urandom_range(4) == 0);
        lat = (lat_knob > 0) ? lat_knob : int'($urandom_range(6, 1));
        t_done = c + 1 + lat;
        t_last_wait = timeout_txn ? c + 1 + TO : t_done;
        t_resp = t_last_wait + 1;
        final_val = {$urandom, $urandom};
        e.err = timeout_txn;
        if (timeout_txn) begin
          t_final = -1; e.result = '0;
        end else if ($urandom_range(5) == 0) begin
          t_final = -1; e.result = '0;
        end else begin
          t_final = int'($urandom_range(t_done, c + 2)); e.result = final_val;
        end
        e.id = win;
        e.t_resp = t_resp;
        exp_q.push_back(e);
        grants.push_back(win);
      end
    end
  endtask

  task automatic drain();
    mask = '0; p_withdraw = 100; p_busy = 0; p_disable = 0;
    applyStimulus(TO + 10);
    p_withdraw = 0;
  endtask

  initial begin : stimulus
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset, then all ports continuously valid with a two-cycle VPU.
    mask = 4'hF; p_new = 100; p_withdraw = 0; p_busy = 0; p_disable = 0;
    lat_knob = 2; rst_left = 3;
    applyStimulus(36);
    checkOutput("fair_count", 64'(grants.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      checkOutput("fair_order", 64'(grants[i]), 64'(exp_order[i]));
    drain();

    // Single request from port 2 with fixed operands, done 5 cycles after start.
    mask = 4'b0100; p_new = 100; lat_knob = 5; use_fixed = 1;
    applyStimulus(1);
    mask = '0; use_fixed = 0;
    applyStimulus(12);

    // Busy gating: port 0 waits while vp_busy is high.
    mask = 4'b0001; p_busy = 100; lat_knob = 3;
    applyStimulus(5);
    mask = '0; p_busy = 0;
    applyStimulus(10);

    // Timeout with late completions, then a normal request.
    mask = 4'b0001; lat_knob = -2;
    applyStimulus(1);
    mask = '0;
    applyStimulus(TO + 8);
    mask = 4'b0010; lat_knob = 3;
    applyStimulus(1);
    mask = '0;
    applyStimulus(10);

    // enable drops while an operation is in flight; port 3 waits until re-enabled.
    mask = 4'b0001; lat_knob = 6;
    applyStimulus(1);
    mask = 4'b1000; p_disable = 100;
    applyStimulus(18);
    mask = '0; p_disable = 0;
    applyStimulus(10);
    drain();

    // Randomized traffic.
    mask = 4'hF; p_new = 30; p_withdraw = 5; p_busy = 20; p_disable = 10; lat_knob = -1;
    applyStimulus(1500);
    drain();

    // Reset in the middle of a hung operation; port 0 must win first afterwards.
    mask = 4'b0001; p_new = 100; lat_knob = -2;
    applyStimulus(1);
    mask = 4'hF;
    applyStimulus(5);
    grants.delete();
    rst_left = 2;
    applyStimulus(3);
    checkOutput("post_reset_grant_count", 64'(grants.size()), 64'd1);
    if (grants.size() > 0) checkOutput("post_reset_grant", 64'(grants[0]), 64'd0);
    lat_knob = -1;
    drain();
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
